mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 212 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle controller for a small MIPS subset: decodes opcode/funct and
// sequences FETCH/DECODE/EXEC/MEM/WB, driving datapath selects and strobes.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ALUzero,
  output logic       IR_WE,
  output logic       PC_WE,
  output logic [1:0] WACtrl,
  output logic [1:0] WDCtrl,
  output logic [1:0] ALUCtrl,
  output logic       ALUBCtrl,
  output logic       EXTCtrl,
  output logic       DM_WE,
  output logic       DM_RE,
  output logic       GRFWE,
  output logic [1:0] JumpCtrl,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU = 4'd0,
    I_SUBU = 4'd1,
    I_JR   = 4'd2,
    I_ORI  = 4'd3,
    I_LW   = 4'd4,
    I_SW   = 4'd5,
    I_BEQ  = 4'd6,
    I_LUI  = 4'd7,
    I_JAL  = 4'd8,
    I_ILL  = 4'd9
  } instr_t;

  state_t     state_r;
  state_t     next_s;
  instr_t     instr_s;
  logic [1:0] alu_op_s;
  logic       alu_b_s;
  logic       ext_s;
  logic       ir_we_s;
  logic       pc_we_s;
  logic       dm_we_s;
  logic       dm_re_s;
  logic       grfwe_s;

  // Instruction decode; anything not in the supported set becomes I_ILL.
  always_comb begin
    instr_s = I_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: instr_s = I_ADDU;
          6'b100011: instr_s = I_SUBU;
          6'b001000: instr_s = I_JR;
          default:   instr_s = I_ILL;
        endcase
      end
      6'b001101: instr_s = I_ORI;
      6'b100011: instr_s = I_LW;
      6'b101011: instr_s = I_SW;
      6'b000100: instr_s = I_BEQ;
      6'b001111: instr_s = I_LUI;
      6'b000011: instr_s = I_JAL;
      default:   instr_s = I_ILL;
    endcase
  end

  // Per-instruction ALU setup, applied from EXEC until the instruction ends.
  always_comb begin
    alu_op_s = 2'b00;
    alu_b_s  = 1'b0;
    ext_s    = 1'b0;
    case (instr_s)
      I_ADDU: begin alu_op_s = 2'b00; alu_b_s = 1'b0; ext_s = 1'b0; end
      I_SUBU: begin alu_op_s = 2'b01; alu_b_s = 1'b0; ext_s = 1'b0; end
      I_ORI:  begin alu_op_s = 2'b10; alu_b_s = 1'b1; ext_s = 1'b0; end
      I_LUI:  begin alu_op_s = 2'b11; alu_b_s = 1'b1; ext_s = 1'b0; end
      I_LW,
      I_SW:   begin alu_op_s = 2'b00; alu_b_s = 1'b1; ext_s = 1'b1; end
      I_BEQ:  begin alu_op_s = 2'b01; alu_b_s = 1'b0; ext_s = 1'b1; end
      default: begin alu_op_s = 2'b00; alu_b_s = 1'b0; ext_s = 1'b0; end
    endcase
  end

  // Next-state and output decode; each instruction pulses PC_WE in its last cycle.
  always_comb begin
    next_s   = S_FETCH;
    ir_we_s  = 1'b0;
    pc_we_s  = 1'b0;
    dm_we_s  = 1'b0;
    dm_re_s  = 1'b0;
    grfwe_s  = 1'b0;
    WACtrl   = 2'b00;
    WDCtrl   = 2'b00;
    ALUCtrl  = 2'b00;
    ALUBCtrl = 1'b0;
    EXTCtrl  = 1'b0;
    JumpCtrl = 2'b00;
    case (state_r)
      S_FETCH: begin
        ir_we_s = 1'b1;
        next_s  = S_DECODE;
      end
      S_DECODE: begin
        case (instr_s)
          I_JR: begin
            pc_we_s  = 1'b1;
            JumpCtrl = 2'b11;
            next_s   = S_FETCH;
          end
          I_ILL: begin
            pc_we_s = 1'b1;
            next_s  = S_FETCH;
          end
          I_JAL:   next_s = S_WB;
          default: next_s = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ALUCtrl  = alu_op_s;
        ALUBCtrl = alu_b_s;
        EXTCtrl  = ext_s;
        case (instr_s)
          I_BEQ: begin
            pc_we_s  = 1'b1;
            JumpCtrl = ALUzero ? 2'b01 : 2'b00;
            next_s   = S_FETCH;
          end
          I_LW, I_SW:                   next_s = S_MEM;
          I_ADDU, I_SUBU, I_ORI, I_LUI: next_s = S_WB;
          default:                      next_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        ALUCtrl  = alu_op_s;
        ALUBCtrl = alu_b_s;
        EXTCtrl  = ext_s;
        case (instr_s)
          I_LW: begin
            dm_re_s = 1'b1;
            next_s  = S_WB;
          end
          I_SW: begin
            dm_we_s = 1'b1;
            pc_we_s = 1'b1;
            next_s  = S_FETCH;
          end
          default: next_s = S_FETCH;
        endcase
      end
      S_WB: begin
        ALUCtrl  = alu_op_s;
        ALUBCtrl = alu_b_s;
        EXTCtrl  = ext_s;
        next_s   = S_FETCH;
        case (instr_s)
          I_ADDU, I_SUBU: begin
            grfwe_s = 1'b1;
            pc_we_s = 1'b1;
            WACtrl  = 2'b01;
          end
          I_ORI, I_LUI: begin
            grfwe_s = 1'b1;
            pc_we_s = 1'b1;
          end
          I_LW: begin
            grfwe_s = 1'b1;
            pc_we_s = 1'b1;
            WDCtrl  = 2'b01;
          end
          I_JAL: begin
            grfwe_s  = 1'b1;
            pc_we_s  = 1'b1;
            WACtrl   = 2'b10;
            WDCtrl   = 2'b10;
            JumpCtrl = 2'b10;
          end
          default: grfwe_s = 1'b0;
        endcase
      end
      default: next_s = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Strobes are gated by reset so an aborted instruction cannot write anything.
  assign IR_WE = ir_we_s & reset;
  assign PC_WE = pc_we_s & reset;
  assign DM_WE = dm_we_s & reset;
  assign DM_RE = dm_re_s & reset;
  assign GRFWE = grfwe_s & reset;
  assign state = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed cases plus a random legal
// instruction stream, checked per cycle against a table-driven cycle model.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ALUzero;
  logic       IR_WE;
  logic       PC_WE;
  logic [1:0] WACtrl;
  logic [1:0] WDCtrl;
  logic [1:0] ALUCtrl;
  logic       ALUBCtrl;
  logic       EXTCtrl;
  logic       DM_WE;
  logic       DM_RE;
  logic       GRFWE;
  logic [1:0] JumpCtrl;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int pc_we_cnt = 0;
  int instr_cnt = 0;
  int overlap_cnt = 0;

  logic [5:0] op_tab [0:8];
  logic [5:0] fn_tab [0:8];

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .ALUzero(ALUzero),
    .IR_WE(IR_WE), .PC_WE(PC_WE), .WACtrl(WACtrl), .WDCtrl(WDCtrl),
    .ALUCtrl(ALUCtrl), .ALUBCtrl(ALUBCtrl), .EXTCtrl(EXTCtrl), .DM_WE(DM_WE),
    .DM_RE(DM_RE), .GRFWE(GRFWE), .JumpCtrl(JumpCtrl), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected-cycle record: {state, IR_WE, PC_WE, WA, WD, ALU, ALUB, EXT, DM_WE, DM_RE, GRFWE, Jump}
  function automatic logic [17:0] ev(input logic [2:0] st, input logic ir, input logic pc,
                                     input logic [1:0] wa, input logic [1:0] wd,
                                     input logic [1:0] alu, input logic alub, input logic ext,
                                     input logic dmwe, input logic dmre, input logic grf,
                                     input logic [1:0] jmp);
    return {st, ir, pc, wa, wd, alu, alub, ext, dmwe, dmre, grf, jmp};
  endfunction

  function automatic logic [17:0] observed();
    return {state, IR_WE, PC_WE, WACtrl, WDCtrl, ALUCtrl, ALUBCtrl, EXTCtrl,
            DM_WE, DM_RE, GRFWE, JumpCtrl};
  endfunction

  // Kinds: 0 addu 1 subu 2 jr 3 ori 4 lw 5 sw 6 beq 7 lui 8 jal 9 illegal.
  // Called at a negedge with the DUT in FETCH; abort_at >= 0 asserts reset at that step.
  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input int abort_at, input string tag);
    logic [17:0] q [$];
    logic [1:0]  a;
    logic        b;
    logic        e;
    case (k)
      0:       begin a = 2'b00; b = 1'b0; e = 1'b0; end
      1:       begin a = 2'b01; b = 1'b0; e = 1'b0; end
      3:       begin a = 2'b10; b = 1'b1; e = 1'b0; end
      4, 5:    begin a = 2'b00; b = 1'b1; e = 1'b1; end
      6:       begin a = 2'b01; b = 1'b0; e = 1'b1; end
      7:       begin a = 2'b11; b = 1'b1; e = 1'b0; end
      default: begin a = 2'b00; b = 1'b0; e = 1'b0; end
    endcase
    q.push_back(ev(3'd0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    case (k)
      2: q.push_back(ev(3'd1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
      9: q.push_back(ev(3'd1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
      8: begin
        q.push_back(ev(3'd1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        q.push_back(ev(3'd4, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10));
      end
      default: begin
        q.push_back(ev(3'd1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        q.push_back(ev(3'd2, 1'b0, (k == 6), 2'b00, 2'b00, a, b, e, 1'b0, 1'b0, 1'b0,
                       (k == 6 && zero) ? 2'b01 : 2'b00));
        if (k == 4) begin
          q.push_back(ev(3'd3, 1'b0, 1'b0, 2'b00, 2'b00, a, b, e, 1'b0, 1'b1, 1'b0, 2'b00));
          q.push_back(ev(3'd4, 1'b0, 1'b1, 2'b00, 2'b01, a, b, e, 1'b0, 1'b0, 1'b1, 2'b00));
        end else if (k == 5) begin
          q.push_back(ev(3'd3, 1'b0, 1'b1, 2'b00, 2'b00, a, b, e, 1'b1, 1'b0, 1'b0, 2'b00));
        end else if (k == 0 || k == 1) begin
          q.push_back(ev(3'd4, 1'b0, 1'b1, 2'b01, 2'b00, a, b, e, 1'b0, 1'b0, 1'b1, 2'b00));
        end else if (k == 3 || k == 7) begin
          q.push_back(ev(3'd4, 1'b0, 1'b1, 2'b00, 2'b00, a, b, e, 1'b0, 1'b0, 1'b1, 2'b00));
        end
      end
    endcase
    for (int i = 0; i < q.size(); i++) begin
      opcode  = op;
      funct   = fn;
      ALUzero = (k == 6 && i == 2) ? zero : 1'($urandom_range(1, 0));
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s_abort_strobes", tag),
              {27'd0, IR_WE, PC_WE, DM_WE, DM_RE, GRFWE}, 32'd0);
        return;
      end
      #1;
      check($sformatf("%s[%0d]", tag, i), {14'd0, observed()}, {14'd0, q[i]});
      if (PC_WE) pc_we_cnt++;
      if (GRFWE && DM_WE) overlap_cnt++;
      @(negedge clk);
    end
    instr_cnt++;
  endtask

  // Completes the two-cycle reset started by an aborted instruction.
  task automatic finish_reset(input string tag);
    @(negedge clk);
    #1;
    check($sformatf("%s_state_in_reset", tag), {29'd0, state}, 32'd0);
    check($sformatf("%s_strobes_in_reset", tag),
          {27'd0, IR_WE, PC_WE, DM_WE, DM_RE, GRFWE}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check($sformatf("%s_state_after", tag), {29'd0, state}, 32'd0);
    check($sformatf("%s_irwe_after", tag), {31'd0, IR_WE}, 32'd1);
  endtask

  initial begin
    int k;
    op_tab[0] = 6'b000000; fn_tab[0] = 6'b100001;
    op_tab[1] = 6'b000000; fn_tab[1] = 6'b100011;
    op_tab[2] = 6'b000000; fn_tab[2] = 6'b001000;
    op_tab[3] = 6'b001101; fn_tab[3] = 6'b000000;
    op_tab[4] = 6'b100011; fn_tab[4] = 6'b000000;
    op_tab[5] = 6'b101011; fn_tab[5] = 6'b000000;
    op_tab[6] = 6'b000100; fn_tab[6] = 6'b000000;
    op_tab[7] = 6'b001111; fn_tab[7] = 6'b000000;
    op_tab[8] = 6'b000011; fn_tab[8] = 6'b000000;

    reset   = 1'b0;
    opcode  = 6'b100011;
    funct   = 6'b000000;
    ALUzero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_strobes", {27'd0, IR_WE, PC_WE, DM_WE, DM_RE, GRFWE}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_instr(0, op_tab[0], fn_tab[0], 1'b0, -1, "addu");
    run_instr(4, op_tab[4], 6'b101010, 1'b0, -1, "lw");
    run_instr(5, op_tab[5], 6'b010101, 1'b1, -1, "sw");
    run_instr(6, op_tab[6], 6'b000000, 1'b1, -1, "beq_taken");
    run_instr(6, op_tab[6], 6'b000000, 1'b0, -1, "beq_not_taken");
    run_instr(8, op_tab[8], 6'b111111, 1'b0, -1, "jal");
    run_instr(2, op_tab[2], fn_tab[2], 1'b0, -1, "jr");
    run_instr(9, 6'b111111, 6'b000000, 1'b0, -1, "illegal_op");
    run_instr(9, 6'b000000, 6'b000000, 1'b0, -1, "illegal_funct");
    run_instr(1, op_tab[1], fn_tab[1], 1'b0, -1, "subu");
    run_instr(3, op_tab[3], 6'b100001, 1'b0, -1, "ori");
    run_instr(7, op_tab[7], 6'b001000, 1'b0, -1, "lui");

    run_instr(4, op_tab[4], 6'b000000, 1'b0, 4, "lw_wb_reset");
    finish_reset("lw_wb_reset");
    run_instr(5, op_tab[5], 6'b000000, 1'b0, 3, "sw_mem_reset");
    finish_reset("sw_mem_reset");

    pc_we_cnt   = 0;
    instr_cnt   = 0;
    overlap_cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      k = int'($urandom_range(8, 0));
      run_instr(k, op_tab[k], (op_tab[k] == 6'b000000) ? fn_tab[k] : 6'($urandom),
                1'($urandom_range(1, 0)), -1, "rand");
    end
    check("rand_pc_we_count", pc_we_cnt, instr_cnt);
    check("rand_instr_count", instr_cnt, 32'd1000);
    check("rand_grfwe_dmwe_overlap", overlap_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
